// File: rtl/fc_pkg.sv
// Shared definitions for the FC layer blocks: input-buffer FSM states and
// vertical crossbar tile count helper.
package fc_pkg;

  typedef enum logic [1:0] {
    s_ibuf_fill,
    s_ibuf_stream,
    s_ibuf_done
  } t_ibuf_state;

  function automatic int unsigned f_v_cim_tiles(input int unsigned num_elements,
                                                input int unsigned xbar_size);
    return (num_elements + xbar_size - 1) / xbar_size;
  endfunction

endpackage

// File: rtl/fc_ibuf_slice.sv
// Combinational bit-plane extractor: selects one bit of every buffered
// activation and lays it out per crossbar tile, zero-padding unused rows.
module fc_ibuf_slice
  import fc_pkg::*;
#(
  parameter int unsigned DATA_SIZE    = 8,
  parameter int unsigned NUM_ELEMENTS = 512,
  parameter int unsigned XBAR_SIZE    = 256,
  parameter int unsigned V_CIM_TILES  = f_v_cim_tiles(NUM_ELEMENTS, XBAR_SIZE),
  parameter int unsigned BIT_W        = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1
) (
  input  logic [NUM_ELEMENTS-1:0][DATA_SIZE-1:0] i_buf,
  input  logic [BIT_W-1:0]                       i_bit_idx,
  output logic [V_CIM_TILES-1:0][XBAR_SIZE-1:0]  o_plane
);

  for (genvar t = 0; t < V_CIM_TILES; t++) begin : g_tile
    for (genvar r = 0; r < XBAR_SIZE; r++) begin : g_row
      if (t * XBAR_SIZE + r < NUM_ELEMENTS) begin : g_live
        assign o_plane[t][r] = i_buf[t * XBAR_SIZE + r][i_bit_idx];
      end else begin : g_pad
        assign o_plane[t][r] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fc_ibuf.sv
// FC layer input buffer: collects activation beats, then streams them to the
// crossbar tiles one bit-plane at a time. FC_IBUF_MSB_FIRST_EN selects MSB-first order.
module fc_ibuf
  import fc_pkg::*;
#(
  parameter int unsigned DATA_SIZE    = 8,
  parameter int unsigned NUM_ELEMENTS = 512,
  parameter int unsigned WR_ELEMS     = 16,
  parameter int unsigned XBAR_SIZE    = 256,
  parameter int unsigned V_CIM_TILES  = f_v_cim_tiles(NUM_ELEMENTS, XBAR_SIZE),
  parameter int unsigned PTR_W        = $clog2(NUM_ELEMENTS + 1),
  parameter int unsigned BIT_W        = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_write_enable,
  input  logic [WR_ELEMS-1:0][DATA_SIZE-1:0]    i_data,
  input  logic                                  i_start,
  output logic                                  o_ready,
  output logic [V_CIM_TILES-1:0][XBAR_SIZE-1:0] o_cim_data,
  output logic                                  o_cim_valid,
  output logic [BIT_W-1:0]                      o_bit_idx,
  input  logic                                  i_cim_ready,
  output logic                                  o_done
);

  t_ibuf_state                           r_state;
  t_ibuf_state                           w_state_nxt;
  logic [NUM_ELEMENTS-1:0][DATA_SIZE-1:0] r_buf;
  logic [PTR_W-1:0]                      r_wr_ptr;
  logic [PTR_W:0]                        w_ptr_sum;
  logic [BIT_W-1:0]                      r_plane_cnt;
  logic [BIT_W-1:0]                      w_bit_idx;
  logic                                  w_handshake;
  logic                                  w_last_plane;
  logic [V_CIM_TILES-1:0][XBAR_SIZE-1:0] w_plane;

  assign w_handshake  = (r_state == s_ibuf_stream) && i_cim_ready;
  assign w_last_plane = (r_plane_cnt == BIT_W'(DATA_SIZE - 1));
  assign w_ptr_sum    = {1'b0, r_wr_ptr} + (PTR_W + 1)'(WR_ELEMS);

  always_ff @(posedge clk) begin
    if (rst) r_state <= s_ibuf_fill;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_ready     = 1'b0;
    o_cim_valid = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      s_ibuf_fill: begin
        o_ready = 1'b1;
        if (i_start) w_state_nxt = s_ibuf_stream;
      end
      s_ibuf_stream: begin
        o_cim_valid = 1'b1;
        if (w_handshake && w_last_plane) w_state_nxt = s_ibuf_done;
      end
      s_ibuf_done: begin
        o_done      = 1'b1;
        w_state_nxt = s_ibuf_fill;
      end
      default: w_state_nxt = s_ibuf_fill;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || r_state == s_ibuf_done) begin
      r_buf       <= '0;
      r_wr_ptr    <= '0;
      r_plane_cnt <= '0;
    end else begin
      if (r_state == s_ibuf_fill && i_write_enable) begin
        // Each slot matches at most one lane of the beat; slots past the end simply never match.
        for (int unsigned n = 0; n < NUM_ELEMENTS; n++) begin
          for (int unsigned i = 0; i < WR_ELEMS; i++) begin
            if (i <= n && r_wr_ptr == PTR_W'(n - i)) r_buf[n] <= i_data[i];
          end
        end
        r_wr_ptr <= (w_ptr_sum >= (PTR_W + 1)'(NUM_ELEMENTS)) ? PTR_W'(NUM_ELEMENTS)
                                                              : w_ptr_sum[PTR_W-1:0];
      end
      if (w_handshake) r_plane_cnt <= r_plane_cnt + BIT_W'(1);
    end
  end

`ifdef FC_IBUF_MSB_FIRST_EN
  assign w_bit_idx = BIT_W'(DATA_SIZE - 1) - r_plane_cnt;
`else
  assign w_bit_idx = r_plane_cnt;
`endif

  fc_ibuf_slice #(
    .DATA_SIZE    (DATA_SIZE),
    .NUM_ELEMENTS (NUM_ELEMENTS),
    .XBAR_SIZE    (XBAR_SIZE),
    .V_CIM_TILES  (V_CIM_TILES),
    .BIT_W        (BIT_W)
  ) u_slice (
    .i_buf     (r_buf),
    .i_bit_idx (w_bit_idx),
    .o_plane   (w_plane)
  );

  assign o_cim_data = o_cim_valid ? w_plane : '0;
  assign o_bit_idx  = o_cim_valid ? w_bit_idx : '0;

endmodule

// File: tb/tb_fc_ibuf.sv
// Bench for fc_ibuf: two instances (16 and 14 elements) driven in lockstep and
// compared every cycle against an array-based model of the buffer.
module tb_fc_ibuf;

  localparam int M_FILL   = 0;
  localparam int M_STREAM = 1;
  localparam int M_DONE   = 2;
`ifdef FC_IBUF_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst, we, start, crdy;
  logic [3:0][7:0] data;

  logic            ready_a, valid_a, done_a, ready_b, valid_b, done_b;
  logic [1:0][7:0] cim_a, cim_b;
  logic [2:0]      bit_a, bit_b;

  fc_ibuf #(.DATA_SIZE(8), .NUM_ELEMENTS(16), .WR_ELEMS(4), .XBAR_SIZE(8)) dut_a (
    .clk(clk), .rst(rst), .i_write_enable(we), .i_data(data), .i_start(start),
    .o_ready(ready_a), .o_cim_data(cim_a), .o_cim_valid(valid_a), .o_bit_idx(bit_a),
    .i_cim_ready(crdy), .o_done(done_a));

  fc_ibuf #(.DATA_SIZE(8), .NUM_ELEMENTS(14), .WR_ELEMS(4), .XBAR_SIZE(8)) dut_b (
    .clk(clk), .rst(rst), .i_write_enable(we), .i_data(data), .i_start(start),
    .o_ready(ready_b), .o_cim_data(cim_b), .o_cim_valid(valid_b), .o_bit_idx(bit_b),
    .i_cim_ready(crdy), .o_done(done_b));

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         mode[2];
  int         ptr[2];
  int         k[2];
  logic [7:0] mem[2][16];
  bit         cap_en = 1'b0;
  int         n_valid;
  logic [15:0] capt[8];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ne(input int j);
    return (j == 0) ? 16 : 14;
  endfunction

  function automatic logic [2:0] exp_bit(input int j);
    if (mode[j] != M_STREAM) return 3'd0;
    return MSB_FIRST ? 3'(7 - k[j]) : 3'(k[j]);
  endfunction

  function automatic logic [15:0] exp_data(input int j);
    logic [15:0] v;
    logic [2:0]  b;
    v = '0;
    b = exp_bit(j);
    if (mode[j] == M_STREAM)
      for (int n = 0; n < ne(j); n++) v[n] = mem[j][n][b];
    return v;
  endfunction

  task automatic model_clear(input int j);
    for (int n = 0; n < 16; n++) mem[j][n] = 8'h00;
    ptr[j] = 0;
    k[j]   = 0;
  endtask

  task automatic model_edge(input logic r, input logic w, input logic s, input logic c,
                            input logic [3:0][7:0] d);
    for (int j = 0; j < 2; j++) begin
      if (r) begin
        model_clear(j);
        mode[j] = M_FILL;
      end else begin
        case (mode[j])
          M_FILL: begin
            if (w) begin
              for (int i = 0; i < 4; i++)
                if (ptr[j] + i < ne(j)) mem[j][ptr[j] + i] = d[i];
              ptr[j] = (ptr[j] + 4 > ne(j)) ? ne(j) : ptr[j] + 4;
            end
            if (s) begin
              mode[j] = M_STREAM;
              k[j]    = 0;
            end
          end
          M_STREAM: if (c) begin
            k[j]++;
            if (k[j] == 8) mode[j] = M_DONE;
          end
          default: begin
            model_clear(j);
            mode[j] = M_FILL;
          end
        endcase
      end
    end
  endtask

  task automatic check_outputs();
    check("a.ready", ready_a, mode[0] == M_FILL);
    check("a.valid", valid_a, mode[0] == M_STREAM);
    check("a.done",  done_a,  mode[0] == M_DONE);
    check("a.bit",   bit_a,   exp_bit(0));
    check("a.data",  cim_a,   exp_data(0));
    check("a.wr_ptr", dut_a.r_wr_ptr, ptr[0]);
    check("b.ready", ready_b, mode[1] == M_FILL);
    check("b.valid", valid_b, mode[1] == M_STREAM);
    check("b.done",  done_b,  mode[1] == M_DONE);
    check("b.bit",   bit_b,   exp_bit(1));
    check("b.data",  cim_b,   exp_data(1));
    check("b.wr_ptr", dut_b.r_wr_ptr, ptr[1]);
  endtask

  task automatic cyc(input logic r, input logic w, input logic s, input logic c,
                     input logic [3:0][7:0] d);
    @(negedge clk);
    check_outputs();
    if (cap_en) begin
      if (valid_a) n_valid++;
      if (mode[0] == M_STREAM && c) capt[exp_bit(0)] = cim_a;
    end
    rst = r; we = w; start = s; crdy = c; data = d;
    @(posedge clk);
    model_edge(r, w, s, c, d);
  endtask

  function automatic logic [3:0][7:0] ramp_beat(input int b);
    logic [3:0][7:0] d;
    for (int i = 0; i < 4; i++) d[i] = 8'(4 * b + i);
    return d;
  endfunction

  function automatic logic [3:0][7:0] rnd_beat();
    logic [3:0][7:0] d;
    for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
    return d;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  initial begin
    logic [3:0][7:0] ff_beat;
    ff_beat = {4{8'hFF}};
    rst = 1'b1; we = 1'b0; start = 1'b0; crdy = 1'b0; data = '0;
    repeat (2) @(posedge clk);
    for (int j = 0; j < 2; j++) begin
      model_clear(j);
      mode[j] = M_FILL;
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);

    // ramp 0..15, start with last beat, crossbar always ready
    cap_en = 1'b1; n_valid = 0;
    for (int b = 0; b < 4; b++) cyc(1'b0, 1'b1, b == 3, 1'b1, ramp_beat(b));
    for (int t = 0; t < 12; t++) cyc(1'b0, 1'b0, 1'b0, 1'b1, '0);
    cap_en = 1'b0;
    check("s1.valid_cycles", n_valid, 8);
    check("s1.plane0", capt[0], 16'hAAAA);
    check("s1.plane3", capt[3], 16'hFF00);

    // same data, ready toggling
    for (int b = 0; b < 4; b++) cyc(1'b0, 1'b1, b == 3, 1'b0, ramp_beat(b));
    for (int t = 0; t < 24; t++) cyc(1'b0, 1'b0, 1'b0, t % 2 == 1, '0);

    // two full beats, start on its own cycle
    for (int b = 0; b < 2; b++) cyc(1'b0, 1'b1, 1'b0, 1'b1, ff_beat);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, '0);
    for (int t = 0; t < 12; t++) cyc(1'b0, 1'b0, 1'b0, 1'b1, '0);

    // five full beats: pointer saturation on both instances
    for (int b = 0; b < 5; b++) cyc(1'b0, 1'b1, 1'b0, 1'b1, ff_beat);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, '0);
    for (int t = 0; t < 12; t++) cyc(1'b0, 1'b0, 1'b0, 1'b1, '0);

    // reset while plane 4 is presented, then a short pass from an empty buffer
    for (int b = 0; b < 4; b++) cyc(1'b0, 1'b1, b == 3, 1'b1, ramp_beat(b));
    for (int t = 0; t < 4; t++) cyc(1'b0, 1'b0, 1'b0, 1'b1, '0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, ff_beat);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, '0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, {8'h11, 8'h22, 8'h44, 8'h88});
    cyc(1'b0, 1'b0, 1'b1, 1'b1, '0);
    for (int t = 0; t < 12; t++) cyc(1'b0, 1'b0, 1'b0, 1'b1, '0);

    // randomized passes
    for (int p = 0; p < 40; p++) begin
      int nb;
      bit started;
      nb = $urandom_range(0, 6);
      started = 1'b0;
      for (int b = 0; b < nb; b++) begin
        logic s;
        s = (b == nb - 1) && rb();
        if ($urandom_range(0, 3) == 0) cyc(1'b0, 1'b0, 1'b0, rb(), rnd_beat());
        cyc(1'b0, 1'b1, s, rb(), rnd_beat());
        started = s;
      end
      if (!started) cyc(1'b0, rb(), 1'b1, rb(), rnd_beat());
      for (int t = 0; t < 200 && mode[0] != M_FILL; t++)
        cyc($urandom_range(0, 49) == 0, rb(), rb(), rb(), rnd_beat());
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fc_ibuf.md
# fc_ibuf

Input buffer for a fully connected CIM layer, sitting directly downstream of the previous layer's FC function unit. It collects post-ReLU activations written in parallel bursts and holds them until the producer signals completion. It then streams the activations to the V_CIM_TILES crossbar tiles one bit-plane at a time, with a valid/ready handshake per plane.

## Interface
- DATA_SIZE, 8, activation width in bits (number of bit-planes)
- NUM_ELEMENTS, 512, input neurons of this layer
- WR_ELEMS, 16, elements per write beat; matches the producer's H_CIM_TILES*NUM_CHANNELS
- XBAR_SIZE, 256, crossbar rows per tile
- V_CIM_TILES, (NUM_ELEMENTS+XBAR_SIZE-1)/XBAR_SIZE, vertical tiles (derived)
- PTR_W, $clog2(NUM_ELEMENTS+1), write pointer width (derived)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_write_enable  in  1  write beat valid
- i_data  in  [WR_ELEMS-1:0][DATA_SIZE-1:0]  activations; unsigned
- i_start  in  1  producer finished, last beat may coincide
- o_ready  out  1  buffer accepts writes/start (producer's i_next_ready)
- o_cim_data  out  [V_CIM_TILES-1:0][XBAR_SIZE-1:0]  current bit-plane per tile
- o_cim_valid  out  1  bit-plane valid
- o_bit_idx  out  $clog2(DATA_SIZE) (min 1)  index of presented plane
- i_cim_ready  in  1  crossbar accepts plane
- o_done  out  1  one-cycle pulse, all planes consumed

## Operation
- States (t_ibuf_state): s_ibuf_fill, s_ibuf_stream, s_ibuf_done.
- s_ibuf_fill:
  - o_ready=1.
  - On i_write_enable, element i of the beat is stored at index wr_ptr+i. Indices >= NUM_ELEMENTS are dropped.
  - wr_ptr += WR_ELEMS, saturating at NUM_ELEMENTS.
  - On i_start, go to s_ibuf_stream. A write in the same cycle is stored first.
- s_ibuf_stream:
  - o_ready=0. Writes and i_start are ignored.
  - o_cim_valid=1. Element n drives o_cim_data[n/XBAR_SIZE][n%XBAR_SIZE] = bit plane of element n.
  - Rows with n >= NUM_ELEMENTS are driven 0.
  - Handshake is o_cim_valid && i_cim_ready; it advances to the next plane.
  - The handshake on the last plane moves to s_ibuf_done.
- s_ibuf_done:
  - o_done=1 and o_ready=0 for exactly one cycle.
  - Buffer is zeroed, wr_ptr=0 and plane counter reset, then return to s_ibuf_fill.
- Elements never written in a pass read as 0, because the buffer is cleared on done and on reset.
- When not streaming, o_cim_data=0 and o_cim_valid=0.

## Timing
- Reset values: state s_ibuf_fill, o_ready=1, o_cim_valid=0, o_cim_data=0, o_bit_idx=0, o_done=0, wr_ptr=0, buffer all 0.
- Write at cycle t is visible in streamed data from t+1.
- i_start at cycle t gives o_cim_valid=1 at t+1.
- Each plane is held stable until its handshake. Minimum stream length is DATA_SIZE cycles, with i_cim_ready tied high.
- Final handshake at cycle t gives o_done at t+1 and o_ready=1 at t+2.
- i_cim_ready while not valid is ignored.
- rst mid-stream: on the next edge, return to s_ibuf_fill with all reset values. No o_done is issued.
- o_ready and o_cim_valid are decoded from state. o_cim_data is decoded from buffer and plane counter, with no extra register stage.

## Configuration
- FC_IBUF_MSB_FIRST_EN defined: planes are issued DATA_SIZE-1 down to 0, and o_bit_idx counts down.
- Undefined: planes are issued 0 up to DATA_SIZE-1 (LSB first), and o_bit_idx counts up.
- In both cases o_bit_idx always equals the plane being presented.

## Structure
- Shared package fc_pkg holds:
  - t_ibuf_state enum
  - a function computing V_CIM_TILES from NUM_ELEMENTS and XBAR_SIZE, also usable by fc_func instantiations
- One sub-module, fc_ibuf_slice: purely combinational. It takes buffer and bit index and returns the zero-padded [V_CIM_TILES][XBAR_SIZE] plane.
- The FSM, write pointer, buffer and plane counter live in fc_ibuf.

## Test plan
Configuration: DATA_SIZE=8, NUM_ELEMENTS=16, WR_ELEMS=4, XBAR_SIZE=8 (V=2).
- Four beats carry values 0..15, with i_start on the fourth beat; i_cim_ready is held high. Expect:
  - 8 consecutive valid planes
  - plane 0 for tile 0 = 8'hAA and for tile 1 = 8'hAA
  - plane 3 for tile 0 = 8'h00 and for tile 1 = 8'hFF
  - o_done on the cycle after the last plane
- Same stimulus, but i_cim_ready toggles every other cycle. Expect each plane held until accepted, o_bit_idx sequence 0..7, and no skipped or duplicated plane.
- Two beats of 8'hFF, then i_start. Expect rows 8..15 to read 0 in every plane, and tile 0 rows = 8'hFF.
- NUM_ELEMENTS=14: four beats of 8'hFF. Expect tile 1 rows 6..7 = 0, and wr_ptr saturates at 14.
- Assert rst during plane 4. Expect o_cim_valid=0 and o_ready=1 on the next cycle, no o_done, and the next pass starting from an empty buffer.
- With FC_IBUF_MSB_FIRST_EN defined and the first stimulus, expect o_bit_idx 7..0 and the first plane = bit 7 of each element.
